// File: rtl/conv_unit_scheduler.sv
// conv_unit_scheduler
//   Launches the enabled convolution units one at a time in ascending index
//   order. For each unit it pulses that unit's start, points the finish mux
//   select at it, and waits for a fresh rising edge on its finish line. After
//   the last enabled unit completes it raises a one-cycle done.
//
//   Optional feature macro: CONV_SCHED_TIMEOUT_EN (per-unit watchdog; a unit
//   that stays silent for too long is skipped and a sticky timeout is raised).
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : run request, only looked at while idle
//   unit_mask   : units taking part in the run, captured with start
//   finish_vec  : per-unit finish levels
//   start_vec   : one-hot single-cycle start pulse to the selected unit
//   sel         : index of the active unit (finish mux select)
//   busy        : high from accepted start through the done cycle
//   done        : one-cycle run-complete pulse
//   units_done  : units that completed in the current/last run
//   timeout     : sticky watchdog flag (constant 0 without the macro)
module conv_unit_scheduler #(
  parameter int unsigned N_UNITS   = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_UNITS-1:0] unit_mask,
  input  logic [N_UNITS-1:0] finish_vec,
  output logic [N_UNITS-1:0] start_vec,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done,
  output logic [SEL_W:0]     units_done,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Elaboration-time guard against an unusable configuration.
  if (N_UNITS < 1 || N_UNITS > (1 << SEL_W) || TIMEOUT_W < 2) begin : g_bad_cfg
    $error("conv_unit_scheduler: illegal parameter combination");
  end

  state_e               state_q, state_d;
  logic [N_UNITS-1:0]   mask_q, mask_d;
  logic [N_UNITS-1:0]   fin_q;
  logic [N_UNITS-1:0]   start_vec_q, start_vec_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SEL_W:0]       units_done_q, units_done_d;

  logic                 first_found_c, next_found_c;
  logic [SEL_W-1:0]     first_idx_c, next_idx_c;
  logic                 fin_edge_c;
  logic                 expire_c;

  // Lowest set bit of the incoming mask, and lowest latched bit above sel.
  always_comb begin
    first_found_c = 1'b0;
    first_idx_c   = '0;
    next_found_c  = 1'b0;
    next_idx_c    = '0;
    for (int i = int'(N_UNITS) - 1; i >= 0; i--) begin
      if (unit_mask[i]) begin
        first_found_c = 1'b1;
        first_idx_c   = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_found_c = 1'b1;
        next_idx_c   = SEL_W'(i);
      end
    end
  end

  // Only a 0->1 transition seen while waiting counts as completion.
  assign fin_edge_c = ~fin_q[sel_q] & finish_vec[sel_q];

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;

  // Expire on the WAIT cycle in which the count would reach all-ones.
  assign expire_c = (state_q == S_WAIT) && !fin_edge_c && (wd_q == WD_LAST);

  // Watchdog counter and sticky flag.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (state_q == S_IDLE && start) timeout_d = 1'b0;
    if (state_q == S_LAUNCH)        wd_d = '0;
    else if (state_q == S_WAIT)     wd_d = wd_q + TIMEOUT_W'(1);
    if (expire_c)                   timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire_c = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    start_vec_d  = '0;
    sel_d        = sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    units_done_d = units_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d       = unit_mask;
          units_done_d = '0;
          busy_d       = 1'b1;
          if (first_found_c) begin
            sel_d       = first_idx_c;
            start_vec_d = N_UNITS'(1) << first_idx_c;
            state_d     = S_LAUNCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (fin_edge_c || expire_c) begin
          if (fin_edge_c) units_done_d = units_done_q + (SEL_W+1)'(1);
          if (next_found_c) begin
            sel_d       = next_idx_c;
            start_vec_d = N_UNITS'(1) << next_idx_c;
            state_d     = S_LAUNCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      fin_q        <= '0;
      start_vec_q  <= '0;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      units_done_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      fin_q        <= finish_vec;
      start_vec_q  <= start_vec_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      units_done_q <= units_done_d;
    end
  end

  assign start_vec  = start_vec_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign units_done = units_done_q;

endmodule

// File: tb/tb_conv_unit_scheduler.sv
// Bench for conv_unit_scheduler: a queue-based run model checked every cycle,
// directed scenarios, and literal expectations on pulse order and counts.
module tb_conv_unit_scheduler;

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int unsigned TW = 4;
`else
  localparam int unsigned TW = 16;
`endif
  localparam int WD_LIMIT = (1 << TW) - 1;

  logic       clk, rst_n, start;
  logic [7:0] unit_mask, finish_vec, start_vec;
  logic [2:0] sel;
  logic       busy, done, timeout;
  logic [3:0] units_done;

  logic       auto_en;
  logic [7:0] auto_fin, man_fin;
  int         cnt [8];
  int         rise_cyc [8];
  int         cyc;

  int n_cmp, n_err;

  logic [7:0] pulses[$];
  logic [7:0] exp_p[$];
  logic [2:0] psel[$];
  int         pulse_cyc[$];
  int         done_cnt, done_cyc, busy_cnt, start_cyc;

  conv_unit_scheduler #(.N_UNITS(8), .SEL_W(3), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .unit_mask(unit_mask),
    .finish_vec(finish_vec), .start_vec(start_vec), .sel(sel), .busy(busy),
    .done(done), .units_done(units_done), .timeout(timeout)
  );

  assign finish_vec = auto_en ? auto_fin : man_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Unit emulator: finish drops on its start pulse and rises 5 cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n) begin
        cnt[i] = 0;
        auto_fin[i] = 1'b0;
      end else if (start_vec[i]) begin
        auto_fin[i] = 1'b0;
        cnt[i] = 5;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          auto_fin[i] = 1'b1;
          rise_cyc[i] = cyc;
        end
      end
    end
  end

  // Run model: a queue of units still to launch plus the one being waited on.
  int         m_q[$];
  int         m_cur, m_wcnt;
  bit         m_wait;
  logic [7:0] m_prev_fin;
  logic [7:0] e_sv;
  logic [2:0] e_sel;
  logic       e_busy, e_done, e_to;
  logic [3:0] e_ud;

  always @(posedge clk or negedge rst_n) begin
    bit was_done, was_launch, edge_ok, expired;
    if (!rst_n) begin
      m_q.delete();
      m_cur = 0; m_wcnt = 0; m_wait = 0; m_prev_fin = '0;
      e_sv = '0; e_sel = '0; e_busy = 0; e_done = 0; e_to = 0; e_ud = '0;
    end else begin
      was_done   = e_done;
      was_launch = (e_sv != 0);
      e_sv   = '0;
      e_done = 1'b0;
      if (was_done) begin
        e_busy = 1'b0;
      end else if (!e_busy) begin
        if (start) begin
          m_q.delete();
          for (int i = 0; i < 8; i++) if (unit_mask[i]) m_q.push_back(i);
          e_busy = 1'b1; e_ud = '0; e_to = 1'b0;
          if (m_q.size() == 0) e_done = 1'b1;
          else begin
            m_cur = m_q.pop_front();
            e_sel = 3'(m_cur);
            e_sv  = 8'(1) << m_cur;
            m_wait = 0;
          end
        end
      end else if (was_launch) begin
        m_wait = 1;
        m_wcnt = 0;
      end else if (m_wait) begin
        edge_ok = finish_vec[m_cur] && !m_prev_fin[m_cur];
        expired = 0;
        if (!edge_ok) begin
          m_wcnt++;
          expired = (m_wcnt == WD_LIMIT);
        end
        if (edge_ok || expired) begin
          if (edge_ok) e_ud = e_ud + 4'd1;
          else e_to = 1'b1;
          m_wait = 0;
          if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            e_sel = 3'(m_cur);
            e_sv  = 8'(1) << m_cur;
          end else e_done = 1'b1;
        end
      end
      m_prev_fin = finish_vec;
    end
  end

  // Per-cycle compare against the model, plus event recording.
  always @(negedge clk) begin
    check("start_vec",  32'(start_vec),  32'(e_sv));
    check("sel",        32'(sel),        32'(e_sel));
    check("busy",       32'(busy),       32'(e_busy));
    check("done",       32'(done),       32'(e_done));
    check("units_done", 32'(units_done), 32'(e_ud));
    check("timeout",    32'(timeout),    32'(e_to));
    if (start_vec != 0) begin
      pulses.push_back(start_vec);
      psel.push_back(sel);
      pulse_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    pulses.delete(); psel.delete(); pulse_cyc.delete(); exp_p.delete();
    done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 32'(done), 32'(1));
  endtask

  task automatic cmp_pulses(input string nm);
    check({nm, "_npulse"}, 32'(pulses.size()), 32'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < pulses.size(); i++) begin
      check({nm, "_pulse"}, 32'(pulses[i]), 32'(exp_p[i]));
      check({nm, "_sel"}, 32'(psel[i]), 32'($clog2(exp_p[i])));
    end
  endtask

  task automatic kick(input logic [7:0] m);
    unit_mask = m;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; unit_mask = '0; auto_en = 1'b1; man_fin = '0;
    clear_rec();
    repeat (2) step();
    check("rst_start_vec", 32'(start_vec), 32'(0));
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_units_done", 32'(units_done), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    rst_n = 1'b1;
    step();

    // 1: all eight units in order
    clear_rec();
    for (int i = 0; i < 8; i++) exp_p.push_back(8'(1) << i);
    kick(8'hFF);
    wait_done(200);
    check("t1_units_done", 32'(units_done), 32'(8));
    check("t1_model_ud", 32'(e_ud), 32'(8));
    check("t1_busy_in_done", 32'(busy), 32'(1));
    check("t1_first_latency", 32'(pulse_cyc.size() > 0 ? pulse_cyc[0] - start_cyc : -1), 32'(1));
    step();
    check("t1_busy_after", 32'(busy), 32'(0));
    check("t1_done_cnt", 32'(done_cnt), 32'(1));
    cmp_pulses("t1");

    // 2: sparse mask
    clear_rec();
    exp_p.push_back(8'h04); exp_p.push_back(8'h20); exp_p.push_back(8'h80);
    kick(8'b1010_0100);
    wait_done(100);
    check("t2_units_done", 32'(units_done), 32'(3));
    check("t2_done_latency", 32'(done_cyc - rise_cyc[7]), 32'(1));
    check("t2_sel_hold", 32'(sel), 32'(7));
    step();
    check("t2_done_cnt", 32'(done_cnt), 32'(1));
    cmp_pulses("t2");

    // 3: empty mask
    clear_rec();
    kick(8'h00);
    check("t3_done", 32'(done), 32'(1));
    check("t3_done_latency", 32'(done_cyc - start_cyc), 32'(1));
    check("t3_units_done", 32'(units_done), 32'(0));
    repeat (2) step();
    check("t3_busy_cycles", 32'(busy_cnt), 32'(1));
    check("t3_done_cnt", 32'(done_cnt), 32'(1));
    cmp_pulses("t3");

    // 4: stale finish level, foreign edges, restart and mask change mid-run
    clear_rec();
    auto_en = 1'b0;
    man_fin = 8'h01;
    step();
    exp_p.push_back(8'h01); exp_p.push_back(8'h08);
    kick(8'h09);
    unit_mask = 8'hFF;
    repeat (3) begin
      step();
      man_fin[3] = ~man_fin[3];
    end
    start = 1'b1;
    step();
    start = 1'b0;
    man_fin[3] = 1'b1;
    step();
    man_fin[3] = 1'b0;
    repeat (2) step();
    check("t4_sel_hold", 32'(sel), 32'(0));
    check("t4_no_advance", 32'(units_done), 32'(0));
    check("t4_still_busy", 32'(busy), 32'(1));
    check("t4_one_pulse", 32'(pulses.size()), 32'(1));
    man_fin[0] = 1'b0;
    step();
    man_fin[0] = 1'b1;
    step();
    check("t4_launch3", 32'(start_vec), 32'(8'h08));
    step();
    man_fin[3] = 1'b1;
    wait_done(20);
    check("t4_units_done", 32'(units_done), 32'(2));
    step();
    check("t4_done_cnt", 32'(done_cnt), 32'(1));
    cmp_pulses("t4");

    // 5: reset while waiting on unit 4
    clear_rec();
    auto_en = 1'b1;
    kick(8'h31);
    begin
      int n;
      n = 0;
      while (!start_vec[4] && n < 40) begin
        step();
        n++;
      end
    end
    check("t5_launch4", 32'(start_vec), 32'(8'h10));
    step();
    check("t5_sel_before", 32'(sel), 32'(4));
    check("t5_ud_before", 32'(units_done), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_sel", 32'(sel), 32'(0));
    check("t5_async_busy", 32'(busy), 32'(0));
    check("t5_async_ud", 32'(units_done), 32'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("t5_no_done", 32'(done_cnt), 32'(0));
    clear_rec();
    exp_p.push_back(8'h01); exp_p.push_back(8'h02);
    kick(8'h03);
    wait_done(60);
    check("t5_units_done", 32'(units_done), 32'(2));
    step();
    cmp_pulses("t5");

`ifdef CONV_SCHED_TIMEOUT_EN
    // 6: unit 1 never finishes
    clear_rec();
    auto_en = 1'b0;
    man_fin = '0;
    step();
    exp_p.push_back(8'h01); exp_p.push_back(8'h02);
    kick(8'h03);
    step();
    man_fin[0] = 1'b1;
    wait_done(60);
    check("t6_timeout", 32'(timeout), 32'(1));
    check("t6_units_done", 32'(units_done), 32'(1));
    step();
    cmp_pulses("t6");
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
